// File: rtl/uart_pkg.sv
// Shared encodings and MMIO map for the UART transmitter.
// The PARITY encoding is only reached when UART_TX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // MemOrIO decode targets: data push, status read, overflow clear
  localparam logic [31:0] UART_TX_DATA_ADDR   = 32'hFFFF_FC80;
  localparam logic [31:0] UART_TX_STATUS_ADDR = 32'hFFFF_FC84;
  localparam logic [31:0] UART_TX_CLROVF_ADDR = 32'hFFFF_FC88;

  // Status word bit positions as seen by the CPU
  localparam int UART_STAT_BUSY_BIT  = 0;
  localparam int UART_STAT_FULL_BIT  = 1;
  localparam int UART_STAT_EMPTY_BIT = 2;
  localparam int UART_STAT_OVF_BIT   = 3;
  localparam int UART_STAT_CNT_LSB   = 8;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_io_if.sv
// CPU-side bus of the UART transmitter: push strobe, overflow clear, line and status.
// master = CPU / address decode side, slave = uart_tx_io.
interface uart_tx_io_if #(
  parameter int CNT_W = 5
) ();

  logic             wr_en;
  logic [7:0]       wr_data;
  logic             clr_ovf;
  logic             tx;
  logic             tx_busy;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;

  modport master (
    output wr_en, wr_data, clr_ovf,
    input  tx, tx_busy, fifo_full, fifo_empty, fifo_count, overflow
  );

  modport slave (
    input  wr_en, wr_data, clr_ovf,
    output tx, tx_busy, fifo_full, fifo_empty, fifo_count, overflow
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous TX FIFO with registered count/full/empty.
// Push when full and pop when empty are ignored; pointers wrap modulo DEPTH.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 5,
  parameter int W     = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  // Acceptance uses the pre-edge flags, so a full FIFO drops a push even if it pops
  assign push_ok = push && !full_q;
  assign pop_ok  = pop && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;

endmodule

// File: rtl/uart_tx_io.sv
// Memory-mapped UART transmitter: TX FIFO drained by an 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | line high; pops the FIFO head when non-empty
// ST_START  | start bit, line low
// ST_DATA   | 8 data bits LSB first from the shift register
// ST_PARITY | even parity of the byte (UART_TX_PARITY_EN only)
// ST_STOP   | stop bit, line high, then back to ST_IDLE
module uart_tx_io
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 200,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_W        = 5
) (
  input  logic        clk,
  input  logic        rstn,
  uart_tx_io_if.slave bus
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);

  uart_state_e                state_q, state_d;
  logic [BAUD_W-1:0]          baud_q, baud_d;
  logic [2:0]                 bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
  logic                       tx_q, tx_d;
  logic                       tx_busy_q, tx_busy_d;
  logic                       overflow_q, overflow_d;
`ifdef UART_TX_PARITY_EN
  logic                       parity_q, parity_d;
`endif

  logic                       pop;
  logic [UART_DATA_BITS-1:0]  pop_data;
  logic [CNT_W-1:0]           fifo_count;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       baud_end;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W),
    .W     (UART_DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (bus.wr_en),
    .push_data (bus.wr_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    if (state_q != ST_IDLE) baud_d = baud_end ? '0 : baud_q + BAUD_W'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = pop_data;
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_d  = even_parity(pop_data);
`endif
        end
      end
      ST_START: if (baud_end) state_d = ST_DATA;
      ST_DATA: begin
        if (baud_end) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (baud_end) state_d = ST_STOP;
`endif
      ST_STOP: if (baud_end) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level is registered from the current state, so tx trails the state by one cycle
  always_comb begin
    tx_d = UART_IDLE_LEVEL;
    unique case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_q;
`endif
      default:   tx_d = UART_IDLE_LEVEL;
    endcase
  end

  // Busy is registered alongside tx so it drops exactly when the stop bit leaves the line
  always_comb begin
    tx_busy_d  = (state_q != ST_IDLE) || !fifo_empty;
    overflow_d = overflow_q;
    if (bus.wr_en && fifo_full) overflow_d = 1'b1;
    else if (bus.clr_ovf)       overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= UART_IDLE_LEVEL;
      tx_busy_q  <= 1'b0;
      overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
      overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign bus.tx         = tx_q;
  assign bus.tx_busy    = tx_busy_q;
  assign bus.fifo_full  = fifo_full;
  assign bus.fifo_empty = fifo_empty;
  assign bus.fifo_count = fifo_count;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_io.sv
// Bench for uart_tx_io: frame-position reference model checked every cycle,
// a line decoder, and directed plus randomized pushes.
module tb_uart_tx_io;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * CPB;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  uart_tx_io_if #(.CNT_W(CW)) bus ();

  uart_tx_io #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .CNT_W        (CW)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of accepted bytes plus position within the current frame
  logic [7:0] m_q[$];
  logic [7:0] m_sent[$];
  logic [7:0] m_cur;
  bit         m_active = 0;
  int         m_pos    = 0;
  bit         m_ovf    = 0;
  bit         m_valid  = 0;
  bit         e_tx     = 1;
  bit         e_busy   = 0;
  int         m_pre;
  bit         m_drop;

  function automatic bit line_level(input int p, input logic [7:0] b);
    int bi;
    bi = p / CPB;
    if (bi == 0) return 1'b0;
    if (bi <= 8) return b[bi-1];
`ifdef UART_TX_PARITY_EN
    if (bi == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    m_valid = 1;
    if (!rstn) begin
      m_q.delete();
      m_active = 0;
      m_pos    = 0;
      m_ovf    = 0;
      e_tx     = 1;
      e_busy   = 0;
    end else begin
      e_tx   = m_active ? line_level(m_pos, m_cur) : 1'b1;
      e_busy = m_active || (m_q.size() != 0);
      m_pre  = m_q.size();
      if (!m_active && m_pre != 0) begin
        m_cur    = m_q.pop_front();
        m_active = 1;
        m_pos    = 0;
        m_sent.push_back(m_cur);
      end else if (m_active) begin
        m_pos++;
        if (m_pos == FL) m_active = 0;
      end
      m_drop = bus.wr_en && (m_pre == DEPTH);
      if (bus.wr_en && !m_drop) m_q.push_back(bus.wr_data);
      if (m_drop)            m_ovf = 1;
      else if (bus.clr_ovf)  m_ovf = 0;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("tx",         bus.tx,         e_tx);
      check("tx_busy",    bus.tx_busy,    e_busy);
      check("fifo_count", bus.fifo_count, m_q.size());
      check("fifo_full",  bus.fifo_full,  m_q.size() == DEPTH);
      check("fifo_empty", bus.fifo_empty, m_q.size() == 0);
      check("overflow",   bus.overflow,   m_ovf);
    end
  end

  // Line decoder: mid-bit sampling after each falling start edge
  logic [7:0] rx_q[$];
  bit         rx_par_q[$];
  bit         rx_act  = 0;
  bit         rx_prev = 1;
  int         rx_cnt  = 0;
  logic [7:0] rx_b;

  always @(negedge clk) begin
    if (!rx_act) begin
      if (rx_prev && !bus.tx) begin
        rx_act = 1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      for (int i = 0; i < 8; i++)
        if (rx_cnt == CPB * (i + 1) + CPB / 2) rx_b[i] = bus.tx;
`ifdef UART_TX_PARITY_EN
      if (rx_cnt == CPB * 9 + CPB / 2) rx_par_q.push_back(bus.tx);
`endif
      if (rx_cnt == CPB * (NB - 1) + CPB / 2) begin
        check("stop_bit", bus.tx, 1);
        rx_q.push_back(rx_b);
        rx_act = 0;
      end
    end
    rx_prev = bus.tx;
  end

  // Inputs are set at a negedge, sampled at the next posedge; returns at the following negedge
  task automatic tick(input bit we, input logic [7:0] d, input bit co);
    bus.wr_en   = we;
    bus.wr_data = d;
    bus.clr_ovf = co;
    @(posedge clk);
    @(negedge clk);
    bus.wr_en   = 1'b0;
    bus.clr_ovf = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_one(input logic [7:0] b, output int busy_cyc);
    int empty_bad;
    tick(1'b1, b, 1'b0);
    check("push_visible_empty", bus.fifo_empty, 0);
    tick(1'b0, 8'h00, 1'b0);
    check("tx_high_at_pop", bus.tx, 1);
    check("empty_after_pop", bus.fifo_empty, 1);
    tick(1'b0, 8'h00, 1'b0);
    check("start_latency", bus.tx, 0);
    busy_cyc  = 0;
    empty_bad = 0;
    for (int t = 0; t < 200; t++) begin
      if (!bus.tx_busy) break;
      busy_cyc++;
      if (!bus.fifo_empty) empty_bad++;
      tick(1'b0, 8'h00, 1'b0);
    end
    check("empty_during_frame", empty_bad, 0);
    idle(3);
  endtask

  logic [7:0] bytes6[6];
  bit         tx_samp[$];
  int         busy_cyc, s1, s2, lows, n_rand_push;
  bit         r_we, r_co;

  initial begin
    rstn        = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.clr_ovf = 1'b0;
    @(negedge clk);
    idle(2);
    check("rst_tx",    bus.tx,         1);
    check("rst_busy",  bus.tx_busy,    0);
    check("rst_full",  bus.fifo_full,  0);
    check("rst_empty", bus.fifo_empty, 1);
    check("rst_count", bus.fifo_count, 0);
    check("rst_ovf",   bus.overflow,   0);
    rstn = 1'b1;
    idle(2);

    // Single 0x55 frame
    send_one(8'h55, busy_cyc);
    check("busy_cycles_55", busy_cyc, FL);
    check("rx_count_55", rx_q.size(), 1);
    if (rx_q.size() > 0) check("rx_byte_55", rx_q.pop_front(), 8'h55);

`ifdef UART_TX_PARITY_EN
    rx_par_q.delete();
    send_one(8'h07, busy_cyc);
    check("busy_cycles_07", busy_cyc, 44);
    check("rx_par_count_07", rx_par_q.size(), 1);
    if (rx_par_q.size() > 0) check("parity_07", rx_par_q.pop_front(), 1);
    send_one(8'h03, busy_cyc);
    check("rx_par_count_03", rx_par_q.size(), 1);
    if (rx_par_q.size() > 0) check("parity_03", rx_par_q.pop_front(), 0);
    rx_q.delete();
`endif

    // Back-to-back frames
    tick(1'b1, 8'hA3, 1'b0);
    tick(1'b1, 8'h0F, 1'b0);
    tx_samp.delete();
    for (int t = 0; t < 2 * FL + 20; t++) begin
      tx_samp.push_back(bus.tx);
      tick(1'b0, 8'h00, 1'b0);
    end
    s1 = -1;
    s2 = -1;
    for (int i = 0; i < tx_samp.size(); i++)
      if (s1 < 0 && !tx_samp[i]) s1 = i;
    if (s1 >= 0)
      for (int i = s1 + (NB - 1) * CPB; i < tx_samp.size(); i++)
        if (s2 < 0 && !tx_samp[i]) s2 = i;
    check("first_start_idx", s1, 1);
    check("b2b_spacing", s2 - s1, FL + 1);
    check("rx_count_b2b", rx_q.size(), 2);
    if (rx_q.size() >= 2) begin
      check("rx_byte_a3", rx_q[0], 8'hA3);
      check("rx_byte_0f", rx_q[1], 8'h0F);
    end
    rx_q.delete();
    idle(5);

    // Six consecutive pushes into a depth-4 FIFO, then push-while-full during a pop
    for (int i = 0; i < 6; i++) bytes6[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) tick(1'b1, bytes6[i], 1'b0);
    check("six_count", bus.fifo_count, DEPTH);
    check("six_full",  bus.fifo_full,  1);
    check("six_ovf",   bus.overflow,   1);
    tick(1'b0, 8'h00, 1'b1);
    check("clr_ovf", bus.overflow, 0);
    idle(FL - 5);
    tick(1'b1, 8'hEE, 1'b0);
    check("fullpop_ovf",   bus.overflow,   1);
    check("fullpop_count", bus.fifo_count, DEPTH - 1);
    check("fullpop_full",  bus.fifo_full,  0);
    tick(1'b0, 8'h00, 1'b1);
    idle((FL + 1) * 5 + 10);
    check("rx_count_six", rx_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < rx_q.size()) check("rx_byte_six", rx_q[i], bytes6[i]);
    rx_q.delete();

    // Reset during DATA bit 3 of 0xFF with two bytes queued
    tick(1'b1, 8'hFF, 1'b0);
    tick(1'b1, 8'h12, 1'b0);
    tick(1'b1, 8'h34, 1'b0);
    check("pre_reset_count", bus.fifo_count, 2);
    idle(16);
    rstn = 1'b0;
    tick(1'b0, 8'h00, 1'b0);
    rstn = 1'b1;
    check("midrst_tx",    bus.tx,         1);
    check("midrst_count", bus.fifo_count, 0);
    check("midrst_busy",  bus.tx_busy,    0);
    lows = 0;
    for (int t = 0; t < 80; t++) begin
      if (!bus.tx) lows++;
      tick(1'b0, 8'h00, 1'b0);
    end
    check("no_frame_after_reset", lows, 0);
    rx_q.delete();
    rx_par_q.delete();
    m_sent.delete();

    // Randomized traffic
    n_rand_push = 0;
    for (int c = 0; c < 1500; c++) begin
      r_we = (c < 750) ? ($urandom_range(0, 39) < 3) : ($urandom_range(0, 59) == 0);
      r_co = ($urandom_range(0, 49) == 0);
      if (r_we) n_rand_push++;
      tick(r_we, 8'($urandom), r_co);
    end
    idle((FL + 1) * (DEPTH + 2) + 20);
    check("rand_rx_count", rx_q.size(), m_sent.size());
    for (int i = 0; i < m_sent.size(); i++)
      if (i < rx_q.size()) check("rand_rx_byte", rx_q[i], m_sent[i]);
    check("rand_drained_busy", bus.tx_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
